fifo_reader: RTL and testbench

Drain stage directly downstream of the `fifo` queue. It turns the queue's pop/registered-data interface into a valid/ready stream for the consumer. Because the queue presents a popped word one cycle after `pop`, the block tracks in-flight pops and holds words in a 2-entry skid buffer, so backpressure never drops or duplicates a word. It also owns queue flushing, including the flush applied while in reset.

---
 rtl/fifo_reader_pkg.sv | 9 +
 rtl/fifo_reader_skid.sv | 66 ++++++
 rtl/fifo_reader.sv | 115 +++++++++++
 tb/tb_fifo_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared constants and types for the fifo_reader drain stage.
package fifo_reader_pkg;

  localparam int unsigned SKID_DEPTH    = 2;
  localparam int unsigned CNT_W_DEFAULT = 32;

  typedef logic [1:0] skid_cnt_t;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: holds popped words that the consumer could not take yet.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  logic [WIDTH-1:0] mem_d [SKID_DEPTH];
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  skid_cnt_t        cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (clear) begin
      head_d = 1'b0;
      tail_d = 1'b0;
      cnt_d  = '0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = enq_data;
        tail_d        = ~tail_q;
      end
      if (deq) begin
        head_d = ~head_q;
      end
      // Simultaneous enq and deq leave the occupancy unchanged.
      unique case ({enq, deq})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= '{default: '0};
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign cnt       = cnt_q;

endmodule

// File: rtl/fifo_reader.sv
// Converts the queue's pop/registered-data interface into a valid/ready stream.
// Optional statistics counters are enabled by defining FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_empty,
  input  logic [WIDTH-1:0] q_data,
  output logic             q_pop,
  output logic             q_flush,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_stalls
`endif
);

  localparam skid_cnt_t SkidDepth = skid_cnt_t'(SKID_DEPTH);

  logic             pend_q, pend_d;
  logic [1:0]       cnt;
  logic [1:0]       inflight;
  logic [WIDTH-1:0] head_data;
  logic             skid_enq;
  logic             skid_deq;

  always_comb begin
    inflight = cnt + {1'b0, pend_q};
    q_pop    = rst_n && !flush && !q_empty && (inflight < SkidDepth);
    q_flush  = flush || !rst_n;
    pend_d   = q_pop;

    if (cnt == 2'd0) begin
      out_valid = pend_q && !flush;
      out_data  = q_data;
    end else begin
      out_valid = !flush;
      out_data  = head_data;
    end
    // The queue's data_out is not reset, so mask it while reset is held.
    if (!rst_n) begin
      out_valid = 1'b0;
      out_data  = '0;
    end

    // A bypassed word that is accepted never enters the skid.
    skid_enq = pend_q && !flush && ((cnt != 2'd0) || !out_ready);
    skid_deq = (cnt != 2'd0) && out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end

  fifo_reader_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .enq       (skid_enq),
    .enq_data  (q_data),
    .deq       (skid_deq),
    .head_data (head_data),
    .cnt       (cnt)
  );

`ifdef FIFO_READER_STATS_EN
  localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] stalls_q, stalls_d;

  // Counters survive flush; only reset clears them.
  always_comb begin
    words_d  = words_q;
    stalls_d = stalls_q;
    if (out_valid && out_ready) begin
      words_d = words_q + One;
    end
    if (out_valid && !out_ready) begin
      stalls_d = stalls_q + One;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q  <= '0;
      stalls_q <= '0;
    end else begin
      words_q  <= words_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_words  = words_q;
  assign stat_stalls = stalls_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural queue model driving q_empty/q_data.
module tb_fifo_reader;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         q_empty;
  logic [W-1:0] q_data;
  logic         q_pop;
  logic         q_flush;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef FIFO_READER_STATS_EN
  logic [31:0]  stat_words;
  logic [31:0]  stat_stalls;
`endif

  int           checks = 0;
  int           errors = 0;
  int           pops = 0;
  int           inv_bad = 0;
  int           hs_bad = 0;
  logic         prev_stall;
  logic [W-1:0] prev_data;
  logic [W-1:0] fq[$];
  logic [W-1:0] got[$];
  logic [W-1:0] sent[$];

  always #5 clk = ~clk;

  fifo_reader #(
    .WIDTH (W),
    .CNT_W (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_empty     (q_empty),
    .q_data      (q_data),
    .q_pop       (q_pop),
    .q_flush     (q_flush),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef FIFO_READER_STATS_EN
    ,
    .stat_words  (stat_words),
    .stat_stalls (stat_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    fq.push_back(v);
    q_empty = 1'b0;
  endtask

  // One clock: observe handshake at the settled point, then advance the queue model.
  task automatic cyc();
    logic p, f;
    p = q_pop;
    f = q_flush;
    if (p) pops++;
    if (out_valid && out_ready) got.push_back(out_data);
    if (int'(dut.cnt) + int'(dut.pend_q) > 2) inv_bad++;
    if (prev_stall && !flush && rst_n && !(out_valid && out_data === prev_data)) hs_bad++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    @(posedge clk);
    #1;
    if (f) fq.delete();
    else if (p) q_data = fq.pop_front();
    q_empty = (fq.size() == 0);
    @(negedge clk);
  endtask

  initial begin
    int mism;
    rst_n      = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;
    q_empty    = 1'b1;
    q_data     = 16'hDEAD;
    prev_stall = 1'b0;
    prev_data  = '0;

    // Reset state
    @(negedge clk); #1;
    chk("rst_q_flush", 32'(q_flush), 32'd1);
    chk("rst_q_pop", 32'(q_pop), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
`ifdef FIFO_READER_STATS_EN
    chk("rst_stat_words", stat_words, 32'd0);
    chk("rst_stat_stalls", stat_stalls, 32'd0);
`endif
    cyc();
    rst_n = 1'b1; #1;
    chk("rel_q_flush", 32'(q_flush), 32'd0);

    // Streaming with out_ready high: A,B,C in cycles 1..3
    push(16'h00A1); push(16'h00B2); push(16'h00C3);
    out_ready = 1'b1; #1;
    chk("t1_c0_pop", 32'(q_pop), 32'd1);
    chk("t1_c0_valid", 32'(out_valid), 32'd0);
    cyc(); #1;
    chk("t1_c1_valid", 32'(out_valid), 32'd1);
    chk("t1_c1_data", 32'(out_data), 32'h00A1);
    cyc(); #1;
    chk("t1_c2_data", 32'(out_data), 32'h00B2);
    cyc(); #1;
    chk("t1_c3_data", 32'(out_data), 32'h00C3);
    chk("t1_c3_pop", 32'(q_pop), 32'd0);
    cyc(); #1;
    chk("t1_c4_valid", 32'(out_valid), 32'd0);

    // Backpressure in cycles 1..4
    got.delete(); pops = 0;
    push(16'h00A1); push(16'h00B2); push(16'h00C3);
    out_ready = 1'b1; #1;
    cyc();
    out_ready = 1'b0; #1;
    chk("t2_c1_data", 32'(out_data), 32'h00A1);
    cyc(); #1;
    chk("t2_c2_pop", 32'(q_pop), 32'd0);
    cyc(); #1;
    chk("t2_c3_cnt", 32'(dut.cnt), 32'd2);
    chk("t2_c3_data", 32'(out_data), 32'h00A1);
    cyc(); #1;
    chk("t2_c4_pops", 32'(pops), 32'd2);
    chk("t2_c4_valid", 32'(out_valid), 32'd1);
    cyc();
    out_ready = 1'b1; #1;
    chk("t2_c5_data", 32'(out_data), 32'h00A1);
    cyc(); #1;
    chk("t2_c6_data", 32'(out_data), 32'h00B2);
    cyc(); #1;
    chk("t2_c7_data", 32'(out_data), 32'h00C3);
    chk("t2_c7_valid", 32'(out_valid), 32'd1);
    cyc(); #1;
    chk("t2_c8_valid", 32'(out_valid), 32'd0);
    chk("t2_count", 32'(got.size()), 32'd3);

    // Flush with one word buffered and one in flight
    got.delete();
    push(16'h00D4); push(16'h00E5); push(16'h00F6); push(16'h0107);
    out_ready = 1'b0; #1;
    cyc(); cyc();
    flush = 1'b1; #1;
    chk("t3_pre_cnt", 32'(dut.cnt), 32'd1);
    chk("t3_pre_pend", 32'(dut.pend_q), 32'd1);
    chk("t3_q_flush", 32'(q_flush), 32'd1);
    chk("t3_out_valid", 32'(out_valid), 32'd0);
    chk("t3_q_pop", 32'(q_pop), 32'd0);
    cyc();
    flush = 1'b0;
    push(16'h0118);
    out_ready = 1'b1; #1;
    chk("t3_post_cnt", 32'(dut.cnt), 32'd0);
    chk("t3_post_pend", 32'(dut.pend_q), 32'd0);
    chk("t3_post_valid", 32'(out_valid), 32'd0);
    chk("t3_recover_pop", 32'(q_pop), 32'd1);
    cyc(); #1;
    chk("t3_h_data", 32'(out_data), 32'h0118);
    cyc(); cyc();
    chk("t3_count", 32'(got.size()), 32'd1);

    // Reset asserted mid-stream
    got.delete();
    push(16'h0229); push(16'h033A); push(16'h044B);
    out_ready = 1'b0; #1;
    cyc(); cyc();
    rst_n = 1'b0; #1;
    chk("t4_q_flush", 32'(q_flush), 32'd1);
    chk("t4_q_pop", 32'(q_pop), 32'd0);
    chk("t4_out_valid", 32'(out_valid), 32'd0);
    chk("t4_out_data", 32'(out_data), 32'h0);
    chk("t4_cnt", 32'(dut.cnt), 32'd0);
    cyc();
    rst_n = 1'b1;
    push(16'h055C); push(16'h066D);
    out_ready = 1'b1; #1;
    repeat (4) cyc();
    chk("t4_count", 32'(got.size()), 32'd2);
    chk("t4_w0", 32'(got[0]), 32'h055C);
    chk("t4_w1", 32'(got[1]), 32'h066D);

    // Random push/ready traffic against the in-order reference
    got.delete(); sent.delete(); inv_bad = 0; hs_bad = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 2) != 0 && fq.size() < 8) begin
        logic [W-1:0] v;
        v = W'($urandom);
        push(v);
        sent.push_back(v);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      cyc();
    end
    mism = 0;
    for (int k = 0; k < sent.size(); k++) begin
      if (k >= got.size() || got[k] !== sent[k]) mism++;
    end
    chk("rnd_count", 32'(got.size()), 32'(sent.size()));
    chk("rnd_order", 32'(mism), 32'd0);
    chk("rnd_invariant", 32'(inv_bad), 32'd0);
    chk("rnd_handshake", 32'(hs_bad), 32'd0);

    // Statistics: 5 words, 3 stall cycles, then a flush
    rst_n = 1'b0; #1;
    cyc();
    rst_n = 1'b1;
    got.delete();
    for (int i = 0; i < 5; i++) push(W'(16'h0700 + i));
    out_ready = 1'b1; #1;
    cyc();
    out_ready = 1'b0; #1;
    cyc(); cyc(); cyc();
    out_ready = 1'b1; #1;
    repeat (8) cyc();
    chk("st_count", 32'(got.size()), 32'd5);
    chk("st_last", 32'(got[4]), 32'h0704);
`ifdef FIFO_READER_STATS_EN
    chk("st_words", stat_words, 32'd5);
    chk("st_stalls", stat_stalls, 32'd3);
    flush = 1'b1; #1;
    cyc();
    flush = 1'b0; #1;
    chk("st_words_flush", stat_words, 32'd5);
    chk("st_stalls_flush", stat_stalls, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
